// File: rtl/muldiv_seq_if.sv
// Request/result and shared-ALU signals between the multiply/divide sequencer and the EX stage.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctr;
    logic [WIDTH-1:0] alu_result;
    logic             alu_own;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, alu_result,
        input  alu_a, alu_b, alu_ctr, alu_own, busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, alu_result,
        output alu_a, alu_b, alu_ctr, alu_own, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multu/divu sequencer that borrows the pipeline ALU
// (add/sub/slt only) and leaves its results in HI/LO.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUL     = 3'd1;
    localparam logic [2:0] S_DIV_CMP = 3'd2;
    localparam logic [2:0] S_DIV_SUB = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b100;

    logic [2:0]       state_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] m_reg;      // multiplicand or divisor
    logic [CW-1:0]    count_reg;
    logic             ge_reg;

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH-1:0] rs_shift;
    logic             carry;
    logic             ge;

    // Partial-product addend: multiplicand gated by the current multiplier bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
        assign mul_addend[gi] = m_reg[gi] & lo_reg[0];
    end

    assign rs_shift = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
    // The ALU gives no carry-out, so rebuild it from the operand and sum MSBs.
    assign carry = (hi_reg[WIDTH-1] & mul_addend[WIDTH-1])
                 | ((hi_reg[WIDTH-1] | mul_addend[WIDTH-1]) & ~bus.alu_result[WIDTH-1]);
    // The bit shifted out of HI makes the partial remainder exceed any divisor.
    assign ge = hi_reg[WIDTH-1] | ~bus.alu_result[0];

    always_comb begin
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_ctr = ALU_ADD;
        case (state_reg)
            S_MUL: begin
                bus.alu_a   = hi_reg;
                bus.alu_b   = mul_addend;
                bus.alu_ctr = ALU_ADD;
            end
            S_DIV_CMP: begin
                bus.alu_a   = rs_shift;
                bus.alu_b   = m_reg;
                bus.alu_ctr = ALU_SLT;
            end
            S_DIV_SUB: begin
                bus.alu_a   = hi_reg;
                bus.alu_b   = m_reg;
                bus.alu_ctr = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state_reg == S_MUL) || (state_reg == S_DIV_CMP) || (state_reg == S_DIV_SUB);
    assign bus.alu_own = bus.busy;
    assign bus.done    = (state_reg == S_DONE);
    assign bus.hi      = hi_reg;
    assign bus.lo      = lo_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            m_reg     <= '0;
            count_reg <= '0;
            ge_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        count_reg <= '0;
                        hi_reg    <= '0;
                        if (!bus.op) begin
                            lo_reg    <= bus.rt_val;
                            m_reg     <= bus.rs_val;
                            state_reg <= S_MUL;
                        end else begin
                            lo_reg    <= bus.rs_val;
                            m_reg     <= bus.rt_val;
                            state_reg <= S_DIV_CMP;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_MUL: begin
                    hi_reg    <= {carry, bus.alu_result[WIDTH-1:1]};
                    lo_reg    <= {bus.alu_result[0], lo_reg[WIDTH-1:1]};
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) state_reg <= S_DONE;
                end
                S_DIV_CMP: begin
                    hi_reg    <= rs_shift;
                    lo_reg    <= {lo_reg[WIDTH-2:0], ge};
                    ge_reg    <= ge;
                    state_reg <= S_DIV_SUB;
                end
                S_DIV_SUB: begin
                    if (ge_reg) hi_reg <= bus.alu_result;
                    count_reg <= count_reg + 1'b1;
                    state_reg <= (count_reg == LAST) ? S_DONE : S_DIV_CMP;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of multu/divu vectors plus start-while-busy,
// back-to-back and mid-operation reset sequences, with a behavioural ALU.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;

    muldiv_seq_if #(.WIDTH(32)) bus();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Datapath ALU: add, sub, set-less-than (unsigned compare).
    always_comb begin
        case (bus.alu_ctr)
            3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b100:  bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
            default: bus.alu_result = 32'd0;
        endcase
    end

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Runs until done; returns at the negedge where done is high.
    task automatic wait_done(input string name, input logic is_div, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int poke);
        int   n = 0;
        int   guard = 0;
        bit   proto_ok = 1'b1;
        logic [2:0] exp_ctr;
        while (bus.done !== 1'b1 && guard < 300) begin
            if (bus.alu_own !== bus.busy) proto_ok = 1'b0;
            if (bus.busy === 1'b1) begin
                n++;
                exp_ctr = is_div ? ((n % 2 == 1) ? 3'b100 : 3'b001) : 3'b000;
                if (bus.alu_ctr !== exp_ctr) proto_ok = 1'b0;
            end
            if (poke != 0 && n == poke) begin
                bus.start  = 1'b1;
                bus.op     = 1'b1;
                bus.rs_val = 32'd100;
                bus.rt_val = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        if (bus.busy !== 1'b0 || bus.alu_own !== 1'b0 || bus.alu_ctr !== 3'b000 ||
            bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) proto_ok = 1'b0;
        chk({name, " done_seen"}, 64'(bus.done), 64'd1);
        chk({name, " busy_cycles"}, 64'(n), 64'(exp_busy));
        chk({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({name, " alu_protocol"}, 64'(proto_ok), 64'd1);
    endtask

    initial begin
        bit quiet;

        vecs[0] = '{"mul_3x5",        1'b0, 32'd3,          32'd5,          32'd0,          32'd15};
        vecs[1] = '{"mul_ones",       1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001};
        vecs[2] = '{"mul_2p16",       1'b0, 32'h00010000,   32'h00010000,   32'h00000001,   32'h00000000};
        vecs[3] = '{"mul_shift8",     1'b0, 32'h12345678,   32'h00000100,   32'h00000012,   32'h34567800};
        vecs[4] = '{"div_100_7",      1'b1, 32'd100,        32'd7,          32'd2,          32'd14};
        vecs[5] = '{"div_ones_1",     1'b1, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF};
        vecs[6] = '{"div_by_zero",    1'b1, 32'd1234,       32'd0,          32'd1234,       32'hFFFFFFFF};
        vecs[7] = '{"div_7_100",      1'b1, 32'd7,          32'd100,        32'd7,          32'd0};
        vecs[8] = '{"div_1000_10",    1'b1, 32'd1000,       32'd10,         32'd0,          32'd100};
        vecs[9] = '{"div_msb_3",      1'b1, 32'h80000000,   32'd3,          32'd2,          32'h2AAAAAAA};

        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset alu_own", 64'(bus.alu_own), 64'd0);
        chk("reset hi_lo", {bus.hi, bus.lo}, 64'd0);
        chk("reset alu_drive", {bus.alu_a, bus.alu_b[28:0], bus.alu_ctr}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(vecs[i].name, vecs[i].op, vecs[i].op ? 64 : 32, vecs[i].hi, vecs[i].lo, 0);
            @(negedge clk);
            chk({vecs[i].name, " done_one_cycle"}, {62'd0, bus.done, bus.busy}, 64'd0);
            chk({vecs[i].name, " hold"}, {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
        end

        // Start pulsed in busy cycle 10 of a multiply must be dropped.
        start_op(1'b0, 32'd6, 32'd7);
        wait_done("mul_6x7_poke", 1'b0, 32, 32'd0, 32'd42, 10);

        // Start during DONE launches the next operation immediately.
        start_op(1'b1, 32'd100, 32'd7);
        chk("b2b busy_next", 64'(bus.busy), 64'd1);
        wait_done("b2b_div_100_7", 1'b1, 64, 32'd2, 32'd14, 0);
        @(negedge clk);

        // Reset in cycle 20 of a divide.
        start_op(1'b1, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        chk("pre_reset busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset busy_own", {62'd0, bus.busy, bus.alu_own}, 64'd0);
        chk("mid_reset hi_lo", {bus.hi, bus.lo}, 64'd0);
        quiet = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        chk("mid_reset no_done", 64'(quiet), 64'd1);
        start_op(1'b0, 32'd2, 32'd2);
        wait_done("mul_2x2_after_reset", 1'b0, 32, 32'd0, 32'd4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer that performs unsigned 32x32 multiply and unsigned 32/32 divide by repeatedly driving the shared datapath ALU.
- Uses only ALU add (3'b000), sub (3'b001) and slt (3'b100).
- Sits beside the EX stage. While it owns the ALU (alu_own=1), the top level muxes alu_a/alu_b/alu_ctr into the ALU and stalls the pipeline on busy.
- Results land in HI/LO for mfhi/mflo.

Parameters:
- WIDTH, 32, operand/ALU width; the iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- op  in  1  0 = multu, 1 = divu.
- rs_val  in  WIDTH  multu: multiplicand; divu: dividend.
- rt_val  in  WIDTH  multu: multiplier; divu: divisor.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_ctr  out  3  ALU function select.
- alu_result  in  WIDTH  ALU result, combinational same-cycle return.
- alu_own  out  1  sequencer owns the ALU this cycle; equals busy.
- busy  out  1  operation in progress; pipeline stalls.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  product[63:32] / remainder.
- lo  out  WIDTH  product[31:0] / quotient.

Behaviour:
- Reset, also mid-operation: state=IDLE, hi=lo=0, busy=0, done=0, alu_own=0, alu_a=alu_b=0, alu_ctr=3'b000. Any in-flight operation is discarded.
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE. alu_a, alu_b and alu_ctr are 0 in IDLE and DONE.
- Start acceptance:
  - start is accepted when state is IDLE or DONE.
  - start is ignored in MUL, DIV_CMP and DIV_SUB; it is not queued.
  - On accept: count=0, operands latched, busy goes 1 next cycle.
  - Next state is MUL if op=0, else DIV_CMP.
- multu:
  - Init: HI=0, LO=rt_val, M=rs_val.
  - Each MUL cycle: alu_ctr=000, alu_a=HI, alu_b = LO[0] ? M : 0.
  - Carry is computed locally: c = (a31&b31) | ((a31|b31) & ~result31).
  - Update {HI,LO} <= {c, alu_result, LO[WIDTH-1:1]}; count++.
  - After WIDTH MUL cycles, go to DONE.
  - Latency: start edge, 32 busy cycles, done on the 33rd cycle.
- divu (restoring):
  - Init: HI=0, LO=rs_val, D=rt_val.
  - DIV_CMP:
    - Rs = {HI[WIDTH-2:0], LO[WIDTH-1]}, ob = HI[WIDTH-1].
    - Drive alu_ctr=100, alu_a=Rs, alu_b=D.
    - ge = ob | ~alu_result[0].
    - HI<=Rs, LO<={LO[WIDTH-2:0], ge}; ge is registered.
  - DIV_SUB:
    - Drive alu_ctr=001, alu_a=HI, alu_b=D.
    - If ge, HI<=alu_result (mod 2^WIDTH is correct when ob=1).
    - count++.
    - Go to DONE after the WIDTH-th SUB, else back to DIV_CMP.
  - Latency: 64 busy cycles, done on the 65th cycle.
- Divide by zero needs no special case: it yields lo=all ones, hi=dividend.
- DONE state:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE unless start is accepted in that same cycle.
  - hi/lo hold their values until the next accepted start.
  - hi/lo are updated every busy cycle; they are only architecturally valid at done and after.
- alu_own=busy at all times; never asserted in IDLE or DONE.
- All outputs are registered state, or combinational from state plus registers. No combinational path from start to alu_*.

Test Plan:
- Multiply 3 by 5:
  - Stimulus: reset 2 cycles, then start, op=0, rs=3, rt=5.
  - Required: busy 32 cycles, done in cycle 33, hi=0, lo=15.
- Multiply all-ones:
  - Stimulus: op=0, rs=rt=32'hFFFFFFFF.
  - Required: hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the carry path).
- Divide 100 by 7:
  - Stimulus: op=1, rs=100, rt=7.
  - Required: busy 64 cycles, done in cycle 65, lo=14, hi=2.
  - Required: alu_ctr alternates 100/001 while busy.
- Divide edge cases:
  - op=1, rs=32'hFFFFFFFF, rt=1 → lo=32'hFFFFFFFF, hi=0.
  - op=1, rs=1234, rt=0 → lo=32'hFFFFFFFF, hi=1234.
- Start while busy:
  - Stimulus: pulse start with op=1 at cycle 10 of a multiply of 6 by 7.
  - Required: it is ignored; done at 33, lo=42.
  - Back-to-back: start asserted during DONE launches the next op, with busy=1 the following cycle.
- Reset mid-operation:
  - Stimulus: assert reset at cycle 20 of a divide.
  - Required: next cycle busy=0, alu_own=0, hi=lo=0, no done pulse; a fresh multiply of 2 by 2 then gives lo=4.
